// File: rtl/card_dealer_pkg.sv
// Shared constants and types for the card dealer.
// Defines the result codes, the request opcodes and the handshake FSM states.
// The top level and the test environment both import this package.
package card_pkg;

  // Result codes reported with each ack pulse
  localparam logic [1:0] ERR_OK     = 2'd0;
  localparam logic [1:0] ERR_SEL    = 2'd1;
  localparam logic [1:0] ERR_TAKEN  = 2'd2;
  localparam logic [1:0] ERR_PLAYER = 2'd3;

  // Request opcodes
  localparam logic OP_DEAL   = 1'b0;
  localparam logic OP_RETURN = 1'b1;

  // Handshake FSM: accept a request in IDLE, pulse the ack in ACK
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

endpackage

// File: rtl/card_dealer_onehot_encoder.sv
// One-hot to binary encoder built as an OR tree, with a one-hot validity flag.
// Purely combinational: zero latency.
// No flow control; the output follows the input directly.
module onehot_encoder #(
  parameter int N = 16,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         onehot_ok
);

  localparam logic [N-1:0] ONE = N'(1);

  // Index bit b is the OR of every input bit whose position has bit b set
  always_comb begin
    idx = '0;
    for (int k = 0; k < N; k++) begin
      for (int b = 0; b < W; b++) begin
        if (k[b]) idx[b] = idx[b] | vec[k];
      end
    end
  end

  // Exactly one bit set: nonzero, and clearing the lowest set bit leaves nothing
  always_comb begin
    onehot_ok = (vec != '0) && ((vec & (vec - ONE)) == '0);
  end

endmodule

// File: rtl/card_dealer.sv
// Deals cards from a shared deck to per-player single-card hands and takes them back.
// Latency: a request accepted on one edge is acknowledged in the following cycle.
// Backpressure: req_ready drops for the ack cycle, so at most one request every 2 cycles.
module card_dealer
  import card_pkg::*;
#(
  parameter int N_CARDS   = 9,
  parameter int N_PLAYERS = 2,
  parameter int TURN_MODE = 1,
  parameter int IDX_W     = $clog2(N_CARDS),
  parameter int PL_W      = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_op,
  input  logic [PL_W-1:0]            req_player,
  input  logic [N_CARDS-1:0]         req_sel,
  output logic                       ack_valid,
  output logic [1:0]                 ack_err,
  output logic [N_PLAYERS*IDX_W-1:0] hand_idx,
  output logic [N_PLAYERS-1:0]       hand_valid,
  output logic [N_CARDS-1:0]         deck_avail,
  output logic [PL_W-1:0]            turn,
  output logic                       deck_empty
);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic [1:0]       err;
  logic [1:0]       err_q;
  logic             player_ok;
  logic             held;
  logic             bad_player;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_ok;
  logic [IDX_W-1:0] ret_idx;

  onehot_encoder #(
    .N (N_CARDS),
    .W (IDX_W)
  ) u_enc (
    .vec       (req_sel),
    .idx       (sel_idx),
    .onehot_ok (sel_ok)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state and handshake outputs; ack lasts exactly one cycle
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    ack_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
        if (req_valid) state_nxt = ST_ACK;
      end
      ST_ACK: begin
        ack_valid = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request legality check; player problems outrank select problems, which outrank a taken card
  always_comb begin
    player_ok  = int'(req_player) < N_PLAYERS;
    held       = player_ok ? hand_valid[req_player] : 1'b0;
    ret_idx    = hand_idx[int'(req_player)*IDX_W +: IDX_W];
    bad_player = !player_ok
              || (req_op == OP_DEAL && TURN_MODE != 0 && req_player != turn)
              || (req_op == OP_DEAL && held)
              || (req_op == OP_RETURN && !held);
    err = ERR_OK;
    if (bad_player)                                   err = ERR_PLAYER;
    else if (req_op == OP_DEAL && !sel_ok)            err = ERR_SEL;
    else if (req_op == OP_DEAL && (deck_avail & req_sel) == '0) err = ERR_TAKEN;
  end

  // Game state: commit only on an accepted, error-free request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deck_avail <= '1;
      hand_valid <= '0;
      hand_idx   <= '0;
      turn       <= '0;
      err_q      <= ERR_OK;
    end else if (accept) begin
      err_q <= err;
      if (err == ERR_OK) begin
        if (req_op == OP_DEAL) begin
          hand_idx[int'(req_player)*IDX_W +: IDX_W] <= sel_idx;
          hand_valid[req_player] <= 1'b1;
          deck_avail <= deck_avail & ~req_sel;
          turn <= (turn == PL_W'(N_PLAYERS - 1)) ? '0 : turn + PL_W'(1);
        end else begin
          deck_avail[ret_idx]    <= 1'b1;
          hand_valid[req_player] <= 1'b0;
        end
      end
    end
  end

  // Status outputs
  always_comb begin
    ack_err    = err_q;
    deck_empty = ~|deck_avail;
  end

endmodule
